multi_pass_frame_buffer: RTL and testbench

- Parametrised replay buffer for the thresholding pipeline: captures one frame segment of pixels, then streams it out NUM_PASSES times, e.g. a histogram/threshold pass followed by an apply pass.
- Successor to the two-pass FIFO, adding:
  - a generic pass count;
  - variable frame length closed by a last flag;
  - valid/ready handshakes on both sides;
  - pass index and last-beat tagging;
  - a flush.
- Sits between the pixel source and the threshold compute/apply stages.

---
 rtl/multi_pass_frame_buffer_pkg.sv | 21 ++
 rtl/multi_pass_frame_buffer_if.sv | 37 +++
 rtl/multi_pass_frame_buffer_ram.sv | 25 ++
 rtl/multi_pass_frame_buffer.sv | 135 +++++++++++++
 tb/tb_multi_pass_frame_buffer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_pass_frame_buffer_pkg.sv
// Shared definitions for the multi-pass frame buffer.
//   state_t       : FSM state encoding (IDLE / FILL / REPLAY)
//   mpfb_ptr_w()  : width of frame length and pointers, which must hold the value DEPTH
//   mpfb_addr_w() : width of a RAM word address (0 .. DEPTH-1)
package multi_pass_frame_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    REPLAY = 2'd2
  } state_t;

  function automatic int mpfb_ptr_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int mpfb_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/multi_pass_frame_buffer_if.sv
// Write/read stream bundle of the multi-pass frame buffer.
//   write side : wr_valid, wr_ready, wr_data, wr_last
//   read side  : rd_valid, rd_ready, rd_data, rd_last
//   status     : pass_idx, frame_len, busy
// Modport slave is the buffer itself; modport master is the surrounding logic.
interface multi_pass_frame_buffer_if
  import multi_pass_frame_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int NUM_PASSES = 2
);
  localparam int PTR_W  = mpfb_ptr_w(DEPTH);
  localparam int PASS_W = $clog2(NUM_PASSES) + 1;

  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_last;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_last;
  logic [PASS_W-1:0]     pass_idx;
  logic [PTR_W-1:0]      frame_len;
  logic                  busy;

  modport slave (
    input  wr_valid, wr_data, wr_last, rd_ready,
    output wr_ready, rd_valid, rd_data, rd_last, pass_idx, frame_len, busy
  );

  modport master (
    output wr_valid, wr_data, wr_last, rd_ready,
    input  wr_ready, rd_valid, rd_data, rd_last, pass_idx, frame_len, busy
  );
endinterface

// File: rtl/multi_pass_frame_buffer_ram.sv
// mpfb_ram: simple dual-port storage for one frame segment.
//   clk   : write clock
//   we    : write enable, waddr/wdata : write port (synchronous)
//   raddr : read address, rdata : read data (asynchronous, enables fall-through output)
// Contents are never reset.
module mpfb_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/multi_pass_frame_buffer.sv
// multi_pass_frame_buffer: captures one frame segment (closed by wr_last or by
// reaching DEPTH beats), then replays it NUM_PASSES times with pass tagging.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   flush      : synchronous abort to IDLE, captured frame discarded
//   overrun    : sticky flag, write attempted while replaying
//                (present only when MPFB_OVERRUN_FLAG_EN is defined)
//   bus        : multi_pass_frame_buffer_if.slave write/read streams and status
module multi_pass_frame_buffer
  import multi_pass_frame_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int NUM_PASSES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
`ifdef MPFB_OVERRUN_FLAG_EN
  output logic overrun,
`endif
  multi_pass_frame_buffer_if.slave bus
);
  localparam int PTR_W  = mpfb_ptr_w(DEPTH);
  localparam int ADDR_W = mpfb_addr_w(DEPTH);
  localparam int PASS_W = $clog2(NUM_PASSES) + 1;

  state_t                state, state_nxt;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr, frame_len;
  logic [PASS_W-1:0]     pass_idx;
  logic                  wr_ready, rd_valid, rd_last, busy;
  logic                  wr_fire, rd_fire, final_pass, ram_we;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign final_pass = (pass_idx == PASS_W'(NUM_PASSES - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b0;
    rd_valid  = 1'b0;
    rd_last   = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        wr_ready = 1'b1;
        if (bus.wr_valid) state_nxt = bus.wr_last ? REPLAY : FILL;
      end
      FILL: begin
        wr_ready = 1'b1;
        busy     = 1'b1;
        // Close on wr_last, or when this beat fills the last free slot.
        if (bus.wr_valid && (bus.wr_last || frame_len == PTR_W'(DEPTH - 1)))
          state_nxt = REPLAY;
      end
      REPLAY: begin
        rd_valid = 1'b1;
        busy     = 1'b1;
        rd_last  = (rd_ptr == frame_len - 1'b1);
        if (bus.rd_ready && rd_last && final_pass) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  assign wr_fire = bus.wr_valid && wr_ready;
  assign rd_fire = rd_valid && bus.rd_ready;

  // In IDLE both wr_ptr and frame_len are 0, so the same increment covers the
  // first beat and every FILL beat.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      frame_len <= '0;
      pass_idx  <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr    <= wr_ptr + 1'b1;
        frame_len <= frame_len + 1'b1;
      end
      if (rd_fire) begin
        if (rd_last) begin
          rd_ptr <= '0;
          if (final_pass) begin
            pass_idx  <= '0;
            frame_len <= '0;
            wr_ptr    <= '0;
          end else begin
            pass_idx <= pass_idx + 1'b1;
          end
        end else begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end
  end

  // An aborted beat must not land in memory either.
  assign ram_we = wr_fire && !flush && !reset;

  mpfb_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (bus.wr_data),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

`ifdef MPFB_OVERRUN_FLAG_EN
  always_ff @(posedge clk) begin
    if (reset || flush)                       overrun <= 1'b0;
    else if (bus.wr_valid && state == REPLAY) overrun <= 1'b1;
  end
`endif

  assign bus.wr_ready  = wr_ready;
  assign bus.rd_valid  = rd_valid;
  assign bus.rd_last   = rd_last;
  assign bus.busy      = busy;
  assign bus.pass_idx  = pass_idx;
  assign bus.frame_len = frame_len;
  // Output is forced to zero outside REPLAY so idle/reset data is defined.
  assign bus.rd_data   = (state == REPLAY) ? ram_rdata : '0;
endmodule

// File: tb/tb_multi_pass_frame_buffer.sv
module tb_multi_pass_frame_buffer;
  localparam int DW    = 8;
  localparam int DEP_A = 16;
  localparam int NP_A  = 2;
  localparam int NP_B  = 3;

  logic clk = 1'b0;
  logic reset;
  logic flush;
`ifdef MPFB_OVERRUN_FLAG_EN
  logic overrun_a, overrun_b;
`endif

  always #5 clk = ~clk;

  multi_pass_frame_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEP_A), .NUM_PASSES(NP_A)) bus_a ();
  multi_pass_frame_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEP_A), .NUM_PASSES(NP_B)) bus_b ();

  multi_pass_frame_buffer #(.DATA_WIDTH(DW), .DEPTH(DEP_A), .NUM_PASSES(NP_A)) dut_a (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
`ifdef MPFB_OVERRUN_FLAG_EN
    .overrun (overrun_a),
`endif
    .bus     (bus_a)
  );

  multi_pass_frame_buffer #(.DATA_WIDTH(DW), .DEPTH(DEP_A), .NUM_PASSES(NP_B)) dut_b (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
`ifdef MPFB_OVERRUN_FLAG_EN
    .overrun (overrun_b),
`endif
    .bus     (bus_b)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Behavioural model of DUT A: a frame is a list of pixels; once closed it
  // turns into the full list of NUM_PASSES replayed beats.
  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    int            p;
  } beat_t;

  beat_t         exp_q[$];
  beat_t         rd_log[$];
  logic [DW-1:0] cap[$];
  int            m_flen = 0;
  bit            m_ovr  = 1'b0;

  always @(negedge clk) begin : cmp
    beat_t b;
    if (chk_en) begin
      check("wr_ready", 32'(bus_a.wr_ready), 32'(exp_q.size() == 0));
      check("rd_valid", 32'(bus_a.rd_valid), 32'(exp_q.size() != 0));
      check("busy", 32'(bus_a.busy), 32'(exp_q.size() != 0 || cap.size() != 0));
      if (exp_q.size() != 0) begin
        check("rd_data", 32'(bus_a.rd_data), 32'(exp_q[0].d));
        check("rd_last", 32'(bus_a.rd_last), 32'(exp_q[0].l));
        check("pass_idx", 32'(bus_a.pass_idx), 32'(exp_q[0].p));
        check("frame_len", 32'(bus_a.frame_len), 32'(m_flen));
      end else begin
        check("rd_data_idle", 32'(bus_a.rd_data), 32'd0);
        check("rd_last_idle", 32'(bus_a.rd_last), 32'd0);
        check("pass_idx_idle", 32'(bus_a.pass_idx), 32'd0);
        check("frame_len_fill", 32'(bus_a.frame_len), 32'(cap.size()));
      end
`ifdef MPFB_OVERRUN_FLAG_EN
      check("overrun", 32'(overrun_a), 32'(m_ovr));
`endif
    end
    if (reset || flush) begin
      exp_q.delete();
      cap.delete();
      m_flen = 0;
      m_ovr  = 1'b0;
    end else if (exp_q.size() != 0) begin
      if (bus_a.wr_valid) m_ovr = 1'b1;
      if (bus_a.rd_ready) begin
        if (bus_a.rd_valid) begin
          b.d = bus_a.rd_data;
          b.l = bus_a.rd_last;
          b.p = int'(bus_a.pass_idx);
          rd_log.push_back(b);
        end
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) m_flen = 0;
      end
    end else if (bus_a.wr_valid) begin
      cap.push_back(bus_a.wr_data);
      if (bus_a.wr_last || cap.size() == DEP_A) begin
        m_flen = cap.size();
        for (int p = 0; p < NP_A; p++)
          for (int i = 0; i < cap.size(); i++) begin
            b.d = cap[i];
            b.l = (i == cap.size() - 1);
            b.p = p;
            exp_q.push_back(b);
          end
        cap.delete();
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_beat(input logic [DW-1:0] d, input logic l);
    bus_a.wr_valid = 1'b1;
    bus_a.wr_data  = d;
    bus_a.wr_last  = l;
    step();
    bus_a.wr_valid = 1'b0;
    bus_a.wr_last  = 1'b0;
  endtask

  task automatic read_until(input int target, input int budget, input string name);
    int n;
    n = 0;
    bus_a.rd_ready = 1'b1;
    while (rd_log.size() < target && n < budget) begin
      step();
      n++;
    end
    bus_a.rd_ready = 1'b0;
    check({name, "_read_count"}, 32'(rd_log.size()), 32'(target));
  endtask

  task automatic check_log(input string name, input int idx, input logic [DW-1:0] d,
                           input logic l, input int p);
    if (idx < rd_log.size()) begin
      check({name, "_data"}, 32'(rd_log[idx].d), 32'(d));
      check({name, "_last"}, 32'(rd_log[idx].l), 32'(l));
      check({name, "_pass"}, 32'(rd_log[idx].p), 32'(p));
    end else begin
      check({name, "_present"}, 32'(rd_log.size()), 32'(idx + 1));
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [DW-1:0] seq1 [3];
    int            nlast;
    int            n;
    seq1 = '{8'h10, 8'h20, 8'h30};

    reset = 1'b1;
    flush = 1'b0;
    bus_a.wr_valid = 1'b0; bus_a.wr_data = '0; bus_a.wr_last = 1'b0; bus_a.rd_ready = 1'b0;
    bus_b.wr_valid = 1'b0; bus_b.wr_data = '0; bus_b.wr_last = 1'b0; bus_b.rd_ready = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    check("reset_wr_ready", 32'(bus_a.wr_ready), 32'd1);
    check("reset_rd_valid", 32'(bus_a.rd_valid), 32'd0);
    check("reset_busy", 32'(bus_a.busy), 32'd0);
    check("reset_frame_len", 32'(bus_a.frame_len), 32'd0);
    reset = 1'b0;
    step();

    // Three-beat frame, stalled at first while a blocked write is attempted.
    rd_log.delete();
    for (int i = 0; i < 3; i++) write_beat(seq1[i], i == 2);
    check("t1_first_valid", 32'(bus_a.rd_valid), 32'd1);
    check("t1_first_data", 32'(bus_a.rd_data), 32'h10);
    bus_a.wr_valid = 1'b1;
    bus_a.wr_data  = 8'hEE;
    step();
    step();
    bus_a.wr_valid = 1'b0;
`ifdef MPFB_OVERRUN_FLAG_EN
    check("t1_overrun_set", 32'(overrun_a), 32'd1);
`endif
    check("t1_stall_data", 32'(bus_a.rd_data), 32'h10);
    read_until(6, 40, "t1");
    for (int i = 0; i < 6; i++)
      check_log("t1_beat", i, seq1[i % 3], (i % 3) == 2, i / 3);
    check("t1_wr_ready_after", 32'(bus_a.wr_ready), 32'd1);
    check("t1_rd_valid_after", 32'(bus_a.rd_valid), 32'd0);

    // Sixteen beats without wr_last: auto-close at DEPTH.
    rd_log.delete();
    for (int i = 0; i < 16; i++) write_beat(8'(i), 1'b0);
    check("t2_wr_ready", 32'(bus_a.wr_ready), 32'd0);
    check("t2_rd_valid", 32'(bus_a.rd_valid), 32'd1);
    check("t2_frame_len", 32'(bus_a.frame_len), 32'd16);
    read_until(32, 80, "t2");
    check_log("t2_b15", 15, 8'd15, 1'b1, 0);
    check_log("t2_b16", 16, 8'd0, 1'b0, 1);
    check_log("t2_b31", 31, 8'd15, 1'b1, 1);
    nlast = 0;
    foreach (rd_log[i]) if (rd_log[i].l) nlast++;
    check("t2_last_count", 32'(nlast), 32'd2);

    // Three passes of a single beat on the second instance.
    bus_b.wr_valid = 1'b1; bus_b.wr_data = 8'hAA; bus_b.wr_last = 1'b1;
    step();
    bus_b.wr_valid = 1'b0; bus_b.wr_last = 1'b0;
    check("t3_frame_len", 32'(bus_b.frame_len), 32'd1);
    bus_b.rd_ready = 1'b1;
    for (int p = 0; p < 3; p++) begin
      check("t3_valid", 32'(bus_b.rd_valid), 32'd1);
      check("t3_data", 32'(bus_b.rd_data), 32'hAA);
      check("t3_last", 32'(bus_b.rd_last), 32'd1);
      check("t3_pass", 32'(bus_b.pass_idx), 32'(p));
      step();
    end
    bus_b.rd_ready = 1'b0;
    check("t3_idle_valid", 32'(bus_b.rd_valid), 32'd0);
    check("t3_idle_wr_ready", 32'(bus_b.wr_ready), 32'd1);
    check("t3_idle_busy", 32'(bus_b.busy), 32'd0);

    // Five-beat frame drained under random back-pressure.
    rd_log.delete();
    for (int i = 0; i < 5; i++) write_beat(8'h21 + 8'(i), i == 4);
    n = 0;
    bus_a.rd_ready = 1'($urandom_range(0, 1));
    while (n < 300) begin
      step();
      n++;
      if (rd_log.size() >= 10) break;
      bus_a.rd_ready = 1'($urandom_range(0, 1));
    end
    bus_a.rd_ready = 1'b0;
    check("t4_read_count", 32'(rd_log.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      check_log("t4_beat", i, 8'h21 + 8'(i % 5), (i % 5) == 4, i / 5);

    // Flush in pass 1 at beat 2, then a fresh one-beat frame.
    rd_log.delete();
    for (int i = 0; i < 4; i++) write_beat(8'h61 + 8'(i), i == 3);
    read_until(6, 40, "t5");
    bus_a.rd_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus_a.rd_ready = 1'b0;
    check("t5_rd_valid", 32'(bus_a.rd_valid), 32'd0);
    check("t5_busy", 32'(bus_a.busy), 32'd0);
    check("t5_frame_len", 32'(bus_a.frame_len), 32'd0);
    check("t5_pass_idx", 32'(bus_a.pass_idx), 32'd0);
    check("t5_no_extra_beat", 32'(rd_log.size()), 32'd6);
`ifdef MPFB_OVERRUN_FLAG_EN
    check("t5_overrun_clear", 32'(overrun_a), 32'd0);
`endif
    write_beat(8'h55, 1'b1);
    read_until(8, 20, "t5b");
    check_log("t5_new0", 6, 8'h55, 1'b1, 0);
    check_log("t5_new1", 7, 8'h55, 1'b1, 1);

    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
